count_step_checker: RTL and testbench

Monitor stage directly downstream of the skip counter. Samples the counter value on every `smp_valid`, computes the modulo-2^WIDTH step from the previous sample, and flags illegal steps. The legal steps are +1 and +2, with no two consecutive +2 steps. Each violation is queued as an event record in a small FIFO and drained over a valid/ready interface to the status/debug logic.

---
 rtl/count_step_checker.sv | 185 ++++++++++++++++++
 tb/tb_count_step_checker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/count_step_checker.sv
// count_step_checker
//   Watches the skip counter's sample stream. Each accepted sample is compared
//   with the previous one. The step is taken modulo 2^WIDTH. Legal steps are
//   +1 and +2, and two +2 steps in a row are not allowed. Every illegal step
//   becomes an event record {code, sample}. Records wait in a small FIFO and
//   leave through a valid/ready port.
//
//   Optional feature macro: STEP_CHECK_STATS_EN adds the step/wrap statistics.
//
// Ports
//   clk, rstn        clock; asynchronous active-low reset
//   clr              synchronous clear (FIFO, overflow, stats, FSM -> INIT)
//   smp_valid/data   counter sample input
//   evt_valid/ready  event FIFO head handshake
//   evt_code         01 BAD_DELTA, 10 DOUBLE_SKIP, 11 STALL (0 when empty)
//   evt_data         sample value that raised the head event (0 when empty)
//   overflow         sticky: an event was dropped on a full FIFO
//   halted           monitor stopped after an overflow
//   cnt_step1/step2/wrap  saturating statistics (STEP_CHECK_STATS_EN only)
module count_step_checker #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int STAT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             smp_valid,
    input  logic [WIDTH-1:0] smp_data,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_code,
    output logic [WIDTH-1:0] evt_data,
    output logic             overflow,
    output logic             halted
`ifdef STEP_CHECK_STATS_EN
    ,
    output logic [STAT_W-1:0] cnt_step1,
    output logic [STAT_W-1:0] cnt_step2,
    output logic [STAT_W-1:0] cnt_wrap
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] EVT_NONE   = 2'b00;
    localparam logic [1:0] EVT_BAD    = 2'b01;
    localparam logic [1:0] EVT_DOUBLE = 2'b10;
    localparam logic [1:0] EVT_STALL  = 2'b11;

    // Catch bad configurations at elaboration.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("count_step_checker: DEPTH must be a power of 2 and >= 2");
    end
    if (STAT_W < 1) begin : g_bad_stat_w
        $error("count_step_checker: STAT_W must be >= 1");
    end

    typedef enum logic [1:0] {S_INIT, S_RUN, S_HALT} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   prev_q;
    logic               last_skip_q;
    logic               ovf_q;
    logic [AW-1:0]      wr_q, rd_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH+1:0]   mem_q [DEPTH];

    logic [WIDTH-1:0]   delta;
    logic               is_one, is_two, is_wrap;
    logic               run_smp;
    logic [1:0]         code_d;
    logic               push_req, push, pop, full, drop;
    logic [WIDTH+1:0]   head;

    // The subtraction keeps only WIDTH bits, so the step is modulo 2^WIDTH.
    assign delta   = smp_data - prev_q;
    assign is_one  = (delta == WIDTH'(1));
    assign is_two  = (delta == WIDTH'(2));
    // A legal step that ends below the previous value has wrapped.
    assign is_wrap = (smp_data < prev_q) && (is_one || is_two);
    assign run_smp = smp_valid && !clr && (state_q == S_RUN);

    always_comb begin
        code_d = EVT_NONE;
        if (delta == '0)                 code_d = EVT_STALL;
        else if (is_two && last_skip_q)  code_d = EVT_DOUBLE;
        else if (!is_one && !is_two)     code_d = EVT_BAD;
    end

    assign evt_valid = (cnt_q != '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign pop       = evt_valid && evt_ready && !clr;
    assign push_req  = run_smp && (code_d != EVT_NONE);
    // When the FIFO is full, a pop in the same cycle frees the slot for the push.
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    assign head     = mem_q[rd_q];
    assign evt_code = evt_valid ? head[WIDTH+1:WIDTH] : '0;
    assign evt_data = evt_valid ? head[WIDTH-1:0]     : '0;
    assign overflow = ovf_q;
    assign halted   = (state_q == S_HALT);

    // Monitor FSM together with the FIFO pointers. clr takes priority over
    // both the sample and the pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_INIT;
            prev_q      <= '0;
            last_skip_q <= 1'b0;
            ovf_q       <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
        end else if (clr) begin
            state_q     <= S_INIT;
            ovf_q       <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (smp_valid) begin
                        prev_q      <= smp_data;
                        last_skip_q <= 1'b0;
                        state_q     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (smp_valid) begin
                        prev_q      <= smp_data;
                        last_skip_q <= is_two;
                    end
                    if (drop) begin
                        ovf_q   <= 1'b1;
                        state_q <= S_HALT;
                    end
                end
                default: ;  // S_HALT: samples ignored, FIFO keeps draining
            endcase

            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    // The storage has no reset. Empty slots are never visible, because the
    // head outputs are gated with evt_valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {code_d, smp_data};
    end

`ifdef STEP_CHECK_STATS_EN
    logic [STAT_W-1:0] step1_q, step2_q, wrap_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            step1_q <= '0;
            step2_q <= '0;
            wrap_q  <= '0;
        end else if (clr) begin
            step1_q <= '0;
            step2_q <= '0;
            wrap_q  <= '0;
        end else if (run_smp) begin
            if (is_one  && (step1_q != '1)) step1_q <= step1_q + 1'b1;
            if (is_two  && (step2_q != '1)) step2_q <= step2_q + 1'b1;
            if (is_wrap && (wrap_q  != '1)) wrap_q  <= wrap_q  + 1'b1;
        end
    end

    assign cnt_step1 = step1_q;
    assign cnt_step2 = step2_q;
    assign cnt_wrap  = wrap_q;
`endif

endmodule

// File: tb/tb_count_step_checker.sv
module tb_count_step_checker;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clr = 1'b0;
    logic          smp_valid = 1'b0;
    logic [W-1:0]  smp_data = '0;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [1:0]    evt_code;
    logic [W-1:0]  evt_data;
    logic          overflow;
    logic          halted;
`ifdef STEP_CHECK_STATS_EN
    logic [SW-1:0] cnt_step1, cnt_step2, cnt_wrap;
`endif

    count_step_checker #(.WIDTH(W), .DEPTH(D), .STAT_W(SW)) dut (
        .clk(clk), .rstn(rstn), .clr(clr),
        .smp_valid(smp_valid), .smp_data(smp_data),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_data(evt_data),
        .overflow(overflow), .halted(halted)
`ifdef STEP_CHECK_STATS_EN
        , .cnt_step1(cnt_step1), .cnt_step2(cnt_step2), .cnt_wrap(cnt_wrap)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model. It works on integers and a queue, directly from the
    // step rules.
    typedef struct { int code; int data; } ev_t;
    ev_t q[$];
    int  m_mode;        // 0 = waiting for first sample, 1 = checking, 2 = halted
    int  m_prev;
    bit  m_last2;
    bit  m_ovf;
    int  m_s1, m_s2, m_sw;

    function automatic void model_reset();
        q.delete();
        m_mode = 0; m_prev = 0; m_last2 = 0; m_ovf = 0;
        m_s1 = 0; m_s2 = 0; m_sw = 0;
    endfunction

    function automatic void model_step(bit c, bit v, int d, bit r);
        bit popped;
        int step, code;
        ev_t e;
        if (c) begin
            q.delete(); m_ovf = 0; m_mode = 0; m_s1 = 0; m_s2 = 0; m_sw = 0;
            return;
        end
        popped = (q.size() > 0) && r;
        code = 0;
        if (v && m_mode == 0) begin
            m_prev = d; m_last2 = 0; m_mode = 1;
        end else if (v && m_mode == 1) begin
            step = (d - m_prev + 256) % 256;
            if (step == 0)                 code = 3;
            else if (step == 2 && m_last2) code = 2;
            else if (step > 2)             code = 1;
            if (step == 1 && m_s1 < 65535) m_s1++;
            if (step == 2 && m_s2 < 65535) m_s2++;
            if ((step == 1 || step == 2) && d < m_prev && m_sw < 65535) m_sw++;
            m_last2 = (step == 2);
            m_prev = d;
        end
        if (popped) void'(q.pop_front());
        if (code != 0) begin
            if (q.size() < D) begin
                e.code = code; e.data = d; q.push_back(e);
            end else begin
                m_ovf = 1; m_mode = 2;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("evt_valid", {31'b0, evt_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
        chk("evt_code", {30'b0, evt_code}, (q.size() != 0) ? q[0].code : 0);
        chk("evt_data", {24'b0, evt_data}, (q.size() != 0) ? q[0].data : 0);
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        chk("halted", {31'b0, halted}, (m_mode == 2) ? 32'd1 : 32'd0);
`ifdef STEP_CHECK_STATS_EN
        chk("cnt_step1", {16'b0, cnt_step1}, m_s1);
        chk("cnt_step2", {16'b0, cnt_step2}, m_s2);
        chk("cnt_wrap", {16'b0, cnt_wrap}, m_sw);
`endif
    endtask

    task automatic cycle(input bit c, input bit v, input int d, input bit r);
        clr = c; smp_valid = v; smp_data = W'(d); evt_ready = r;
        @(posedge clk);
        model_step(c, v, d, r);
        #1;
        check_all();
    endtask

    initial begin
        int legal[8] = '{0, 1, 2, 4, 5, 7, 8, 10};
        int wrapv[5] = '{253, 254, 0, 1, 2};
        int d;
        model_reset();
        #2;
        check_all();
        #10 rstn = 1'b1;

        // Legal stream: no events.
        foreach (legal[i]) cycle(0, 1, legal[i], 0);
        chk("legal_no_evt", {31'b0, evt_valid}, 0);
`ifdef STEP_CHECK_STATS_EN
        chk("legal_step1", {16'b0, cnt_step1}, 4);
        chk("legal_step2", {16'b0, cnt_step2}, 3);
`endif

        // Wrap through zero.
        cycle(1, 0, 0, 0);
        foreach (wrapv[i]) cycle(0, 1, wrapv[i], 0);
        chk("wrap_no_evt", {31'b0, evt_valid}, 0);
`ifdef STEP_CHECK_STATS_EN
        chk("wrap_count", {16'b0, cnt_wrap}, 1);
`endif

        // Violations, then drain in order.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 10, 0);
        cycle(0, 1, 12, 0);
        cycle(0, 1, 14, 0);
        chk("dbl_latency_valid", {31'b0, evt_valid}, 1);
        cycle(0, 1, 14, 0);
        cycle(0, 1, 20, 0);
        chk("viol_head_code", {30'b0, evt_code}, 2);
        chk("viol_head_data", {24'b0, evt_data}, 14);
        cycle(0, 0, 0, 1);
        chk("viol_2nd_code", {30'b0, evt_code}, 3);
        chk("viol_2nd_data", {24'b0, evt_data}, 14);
        cycle(0, 0, 0, 1);
        chk("viol_3rd_code", {30'b0, evt_code}, 1);
        chk("viol_3rd_data", {24'b0, evt_data}, 20);
        cycle(0, 0, 0, 1);
        chk("viol_empty", {31'b0, evt_valid}, 0);

        // Overflow: five stalls into a four-deep FIFO.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 5, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 5, 0);
        chk("ovf_not_yet", {31'b0, overflow}, 0);
        cycle(0, 1, 5, 0);
        chk("ovf_set", {31'b0, overflow}, 1);
        chk("halt_set", {31'b0, halted}, 1);
        cycle(0, 1, 6, 0);
        cycle(0, 1, 100, 0);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain_valid", {31'b0, evt_valid}, 1);
            cycle(0, 0, 0, 1);
        end
        chk("ovf_drain_empty", {31'b0, evt_valid}, 0);
        chk("ovf_sticky", {31'b0, overflow}, 1);

        // Full FIFO with a push and a pop in the same cycle.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 9, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 9, 0);
        cycle(0, 1, 9, 1);
        chk("fullpop_no_ovf", {31'b0, overflow}, 0);
        chk("fullpop_no_halt", {31'b0, halted}, 0);
        for (int i = 0; i < 4; i++) begin
            chk("fullpop_occ", {31'b0, evt_valid}, 1);
            cycle(0, 0, 0, 1);
        end
        chk("fullpop_empty", {31'b0, evt_valid}, 0);

        // clr together with a sample and a pending event.
        cycle(0, 1, 30, 0);
        cycle(1, 1, 77, 1);
        chk("clr_empty", {31'b0, evt_valid}, 0);
        chk("clr_ovf", {31'b0, overflow}, 0);
        cycle(0, 1, 200, 0);
        cycle(0, 0, 0, 0);
        chk("clr_init_no_evt", {31'b0, evt_valid}, 0);

        // Asynchronous reset in the middle of a cycle.
        cycle(0, 1, 200, 0);
        chk("pre_rst_valid", {31'b0, evt_valid}, 1);
        #1 rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_async_valid", {31'b0, evt_valid}, 0);
        #1 rstn = 1'b1;

        // Random traffic, mostly near-legal steps.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 255);
            else d = (m_prev + $urandom_range(0, 3)) % 256;
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), d,
                  $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
